// File: rtl/serial_frame_xmtr.sv
// Byte-to-serial framing transmitter: each queued byte leaves MSB-first as a
// 16-bit frame {HEADER, byte}, with an optional forced-zero gap after every frame.
module serial_frame_xmtr #(
   parameter logic [7:0] HEADER   = 8'hA5,
   parameter int         IDLE_GAP = 0
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [7:0] data_in,
   input  logic       writing,
   output logic       data_out,
   output logic       busy,
   output logic       full,
   output logic       dropped
);

   localparam int GAP_W = (IDLE_GAP > 0) ? $clog2(IDLE_GAP + 1) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((IDLE_GAP > 0) ? IDLE_GAP - 1 : 0);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SEND,
      ST_GAP
   } state_t;

   state_t           r_state;
   logic [3:0]       r_bitCount;
   logic [GAP_W-1:0] r_gapCount;
   logic [14:0]      r_shift;
   logic [7:0]       r_hold;
   logic             r_dataOut;
   logic             r_busy;
   logic             r_full;
   logic             r_dropped;

   state_t           w_stateNext;
   logic [3:0]       w_bitCountNext;
   logic [GAP_W-1:0] w_gapCountNext;
   logic [14:0]      w_shiftNext;
   logic             w_dataOutNext;
   logic             w_load;
   logic             w_accept;

   // A new frame may start from idle, straight after the last body bit when
   // there is no gap, or on the closing edge of the gap.
   always_comb begin
      w_load = 1'b0;
      case (r_state)
         ST_IDLE: w_load = r_full;
         ST_SEND: w_load = r_full && (r_bitCount == 4'd15) && (IDLE_GAP == 0);
         ST_GAP:  w_load = r_full && (r_gapCount == GAP_LAST);
         default: w_load = 1'b0;
      endcase
      w_accept = writing && (!r_full || w_load);
   end

   always_comb begin
      w_stateNext    = r_state;
      w_bitCountNext = r_bitCount;
      w_gapCountNext = r_gapCount;
      w_shiftNext    = r_shift;
      w_dataOutNext  = 1'b0;
      if (w_load) begin
         w_shiftNext    = {HEADER[6:0], r_hold};
         w_dataOutNext  = HEADER[7];
         w_bitCountNext = 4'd0;
         w_stateNext    = ST_SEND;
      end else begin
         case (r_state)
            ST_SEND: begin
               if (r_bitCount == 4'd15) begin
                  if (IDLE_GAP > 0) begin
                     w_stateNext    = ST_GAP;
                     w_gapCountNext = '0;
                  end else begin
                     w_stateNext = ST_IDLE;
                  end
               end else begin
                  w_dataOutNext  = r_shift[14];
                  w_shiftNext    = {r_shift[13:0], 1'b0};
                  w_bitCountNext = r_bitCount + 4'd1;
               end
            end
            ST_GAP: begin
               if (r_gapCount == GAP_LAST) begin
                  w_stateNext = ST_IDLE;
               end else begin
                  w_gapCountNext = r_gapCount + GAP_W'(1);
               end
            end
            default: begin
               w_stateNext = r_state;
            end
         endcase
      end
   end

   // Control state and flags; a write refused while the holder is occupied
   // leaves a sticky drop flag that only the next accepted write clears.
   always_ff @(posedge clock) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_bitCount <= 4'd0;
         r_gapCount <= '0;
         r_dataOut  <= 1'b0;
         r_busy     <= 1'b0;
         r_full     <= 1'b0;
         r_dropped  <= 1'b0;
      end else begin
         r_state    <= w_stateNext;
         r_bitCount <= w_bitCountNext;
         r_gapCount <= w_gapCountNext;
         r_dataOut  <= w_dataOutNext;
         r_busy     <= (w_stateNext != ST_IDLE);
         if (w_accept) begin
            r_full    <= 1'b1;
            r_dropped <= 1'b0;
         end else begin
            if (w_load) begin
               r_full <= 1'b0;
            end
            if (writing) begin
               r_dropped <= 1'b1;
            end
         end
      end
   end

   // Data path contents are meaningless after reset, so they carry no reset.
   always_ff @(posedge clock) begin
      r_shift <= w_shiftNext;
      if (w_accept) begin
         r_hold <= data_in;
      end
   end

   assign data_out = r_dataOut;
   assign busy     = r_busy;
   assign full     = r_full;
   assign dropped  = r_dropped;

endmodule

// File: tb/tb_serial_frame_xmtr.sv
// Directed bench for serial_frame_xmtr: one instance with back-to-back frames,
// one with a 3-bit idle gap, both fed from the same stimulus.
module tb_serial_frame_xmtr;

   logic       clock = 1'b0;
   logic       reset;
   logic [7:0] dataIn;
   logic       writing;
   logic       dataOut0, busy0, full0, dropped0;
   logic       dataOut3, busy3, full3, dropped3;

   int          errors = 0;
   int          checks = 0;
   logic [47:0] bits;
   int          busyCnt;
   int          fullCnt;
   int          lineOnes;

   always #5 clock = ~clock;

   serial_frame_xmtr #(.HEADER(8'hA5), .IDLE_GAP(0)) dutGap0 (
      .clock    (clock),
      .reset    (reset),
      .data_in  (dataIn),
      .writing  (writing),
      .data_out (dataOut0),
      .busy     (busy0),
      .full     (full0),
      .dropped  (dropped0)
   );

   serial_frame_xmtr #(.HEADER(8'hA5), .IDLE_GAP(3)) dutGap3 (
      .clock    (clock),
      .reset    (reset),
      .data_in  (dataIn),
      .writing  (writing),
      .data_out (dataOut3),
      .busy     (busy3),
      .full     (full3),
      .dropped  (dropped3)
   );

   task automatic checkOutput(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of inputs, then settle just after the rising edge.
   task automatic applyStimulus(input logic wr, input logic [7:0] d);
      writing = wr;
      dataIn  = d;
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset   = 1'b1;
      writing = 1'b0;
      dataIn  = 8'h00;
      applyStimulus(1'b0, 8'h00);
      applyStimulus(1'b0, 8'h00);
      reset = 1'b0;
      checkOutput("rst_data_out", 64'(dataOut0), 64'(1'b0));
      checkOutput("rst_busy",     64'(busy0),    64'(1'b0));
      checkOutput("rst_full",     64'(full0),    64'(1'b0));
      checkOutput("rst_dropped",  64'(dropped0), 64'(1'b0));
      checkOutput("rst_busy_gap", 64'(busy3),    64'(1'b0));

      // Single byte on an idle line
      applyStimulus(1'b1, 8'h3C);
      checkOutput("t1_full_after_write", 64'(full0),    64'(1'b1));
      checkOutput("t1_line_before",      64'(dataOut0), 64'(1'b0));
      bits = '0; busyCnt = 0; fullCnt = 0;
      for (int k = 0; k < 16; k++) begin
         applyStimulus(1'b0, 8'h00);
         bits = {bits[46:0], dataOut0};
         if (busy0) busyCnt++;
         if (full0) fullCnt++;
      end
      checkOutput("t1_frame",      64'(bits[15:0]), 64'(16'hA53C));
      checkOutput("t1_busy_count", 64'(busyCnt),    64'(16));
      checkOutput("t1_full_count", 64'(fullCnt),    64'(0));
      applyStimulus(1'b0, 8'h00);
      checkOutput("t1_line_after", 64'(dataOut0), 64'(1'b0));
      checkOutput("t1_busy_after", 64'(busy0),    64'(1'b0));
      checkOutput("t1_dropped",    64'(dropped0), 64'(1'b0));

      // Second byte queued while the first frame is on the wire
      applyStimulus(1'b1, 8'h11);
      bits = '0;
      for (int i = 0; i < 32; i++) begin
         applyStimulus(i == 3, 8'h22);
         bits = {bits[46:0], dataOut0};
         if (i == 15) checkOutput("t2_full_before_load", 64'(full0), 64'(1'b1));
         if (i == 16) checkOutput("t2_full_after_load",  64'(full0), 64'(1'b0));
      end
      checkOutput("t2_frames", 64'(bits[31:0]), 64'(32'hA511A522));
      applyStimulus(1'b0, 8'h00);
      checkOutput("t2_line_after", 64'(dataOut0), 64'(1'b0));
      checkOutput("t2_busy_after", 64'(busy0),    64'(1'b0));

      // Overflow: third write refused, later write clears the drop flag
      applyStimulus(1'b1, 8'h01);
      bits = '0;
      for (int i = 0; i < 48; i++) begin
         applyStimulus((i == 0) || (i == 1) || (i == 20),
                       (i == 0) ? 8'h02 : ((i == 1) ? 8'h03 : 8'h04));
         bits = {bits[46:0], dataOut0};
         if (i == 1)  checkOutput("t3_dropped_set",    64'(dropped0), 64'(1'b1));
         if (i == 19) checkOutput("t3_dropped_sticky", 64'(dropped0), 64'(1'b1));
         if (i == 20) checkOutput("t3_dropped_clear",  64'(dropped0), 64'(1'b0));
      end
      checkOutput("t3_frames", 64'(bits), 64'(48'hA501A502A504));
      applyStimulus(1'b0, 8'h00);
      checkOutput("t3_busy_after", 64'(busy0), 64'(1'b0));

      // Write landing exactly on the back-to-back load edge
      applyStimulus(1'b1, 8'h55);
      bits = '0;
      for (int i = 0; i < 48; i++) begin
         applyStimulus((i == 4) || (i == 16), (i == 4) ? 8'h66 : 8'h77);
         bits = {bits[46:0], dataOut0};
         if (i == 16) begin
            checkOutput("t4_full_kept",    64'(full0),    64'(1'b1));
            checkOutput("t4_dropped_zero", 64'(dropped0), 64'(1'b0));
         end
      end
      checkOutput("t4_frames", 64'(bits), 64'(48'hA555A566A577));
      applyStimulus(1'b0, 8'h00);
      checkOutput("t4_busy_after", 64'(busy0), 64'(1'b0));

      // Idle gap of three bits between two queued frames
      reset = 1'b1;
      applyStimulus(1'b0, 8'h00);
      reset = 1'b0;
      applyStimulus(1'b1, 8'hFF);
      bits = '0; busyCnt = 0;
      for (int i = 0; i < 35; i++) begin
         applyStimulus(i == 0, 8'h00);
         bits = {bits[46:0], dataOut3};
         if (busy3) busyCnt++;
      end
      checkOutput("t5_frames_gap", 64'(bits[34:0]), 64'({16'hA5FF, 3'b000, 16'hA500}));
      checkOutput("t5_busy_count", 64'(busyCnt), 64'(35));
      applyStimulus(1'b0, 8'h00);
      checkOutput("t5_line_trailing_gap", 64'(dataOut3), 64'(1'b0));
      checkOutput("t5_busy_trailing_gap", 64'(busy3),    64'(1'b1));
      for (int i = 0; i < 3; i++) applyStimulus(1'b0, 8'h00);
      checkOutput("t5_busy_gap_end", 64'(busy3), 64'(1'b0));

      // Reset in the middle of a frame with a byte queued
      reset = 1'b1;
      applyStimulus(1'b0, 8'h00);
      reset = 1'b0;
      applyStimulus(1'b1, 8'h99);
      bits = '0;
      for (int i = 0; i < 10; i++) begin
         applyStimulus((i == 2) || (i == 3), (i == 2) ? 8'hAA : 8'hBB);
         bits = {bits[46:0], dataOut0};
      end
      checkOutput("t6_prefix",       64'(bits[9:0]), 64'(10'b1010010110));
      checkOutput("t6_dropped_pre",  64'(dropped0),  64'(1'b1));
      checkOutput("t6_full_pre",     64'(full0),     64'(1'b1));
      reset = 1'b1;
      applyStimulus(1'b0, 8'h00);
      reset = 1'b0;
      checkOutput("t6_line_reset",    64'(dataOut0), 64'(1'b0));
      checkOutput("t6_busy_reset",    64'(busy0),    64'(1'b0));
      checkOutput("t6_full_reset",    64'(full0),    64'(1'b0));
      checkOutput("t6_dropped_reset", 64'(dropped0), 64'(1'b0));
      lineOnes = 0; busyCnt = 0;
      for (int i = 0; i < 20; i++) begin
         applyStimulus(1'b0, 8'h00);
         if (dataOut0) lineOnes++;
         if (busy0) busyCnt++;
      end
      checkOutput("t6_line_quiet", 64'(lineOnes), 64'(0));
      checkOutput("t6_busy_quiet", 64'(busyCnt),  64'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
